// File: rtl/bus_pkg.sv
// Shared definitions for the 8085-style bus cycle controller and its decode sequencer.
//   - machine-cycle type encodings (mc_type)
//   - bus controller state enum
//   - one-hot T-state indicator constants, bit order {T1,T2,T3,T4,T5,T6,Treset}
//   - small decode helpers for cycle direction, IO/M and S1/S0 status
package bus_pkg;

  typedef enum logic [2:0] {
    McOf   = 3'b000,
    McMr   = 3'b001,
    McMw   = 3'b010,
    McIor  = 3'b011,
    McIow  = 3'b100,
    McHalt = 3'b101
  } mc_type_e;

  typedef enum logic [3:0] {
    StTreset,
    StT1,
    StT2,
    StTwait,
    StT3,
    StT4,
    StT5,
    StT6,
    StThalt,
    StThold
  } bus_state_e;

  localparam logic [6:0] TsT1     = 7'b1000000;
  localparam logic [6:0] TsT2     = 7'b0100000;
  localparam logic [6:0] TsT3     = 7'b0010000;
  localparam logic [6:0] TsT4     = 7'b0001000;
  localparam logic [6:0] TsT5     = 7'b0000100;
  localparam logic [6:0] TsT6     = 7'b0000010;
  localparam logic [6:0] TsTreset = 7'b0000001;
  localparam logic [6:0] TsNone   = 7'b0000000;

  // 110/111 are reserved and never accepted.
  function automatic logic mc_type_valid(input logic [2:0] t);
    return t <= 3'b101;
  endfunction

  function automatic logic mc_is_read(input logic [2:0] t);
    return (t == McOf) || (t == McMr) || (t == McIor);
  endfunction

  function automatic logic mc_is_write(input logic [2:0] t);
    return (t == McMw) || (t == McIow);
  endfunction

  function automatic logic mc_is_io(input logic [2:0] t);
    return (t == McIor) || (t == McIow);
  endfunction

  // {S1,S0}: fetch 11, read 10, write 01, halt 00.
  function automatic logic [1:0] mc_status(input logic [2:0] t);
    logic [1:0] s;
    case (t)
      McOf:         s = 2'b11;
      McMr, McIor:  s = 2'b10;
      McMw, McIow:  s = 2'b01;
      default:      s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state limiter for the bus cycle controller.
// Counts consecutive TWAIT cycles in which READY is still low. When the limit is reached
// o_expire forces the controller on to T3 and the sticky o_wait_err flag is set.
// MAX_WAIT = 0 disables the limit (o_expire never asserts).
// Ports:
//   i_clk      clock (rising edge)
//   i_rst_n    asynchronous active-low reset
//   i_in_wait  controller is in TWAIT this cycle
//   i_ready    external READY
//   o_expire   this TWAIT is the last one allowed; leave for T3
//   o_wait_err sticky overflow flag, cleared only by reset
module wait_counter #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in_wait,
  input  logic i_ready,
  output logic o_expire,
  output logic o_wait_err
);

  localparam int unsigned CntW     = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam bit          LimitEn  = (MAX_WAIT != 0);
  localparam logic [CntW-1:0] LastCnt = CntW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_err;
  logic            w_stall;

  // r_cnt holds the number of TWAIT cycles already completed in this wait run.
  assign w_stall    = i_in_wait && !i_ready;
  assign o_expire   = LimitEn && w_stall && (r_cnt == LastCnt);
  assign o_wait_err = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_stall && !o_expire) begin
        r_cnt <= r_cnt + CntW'(1);
      end else begin
        r_cnt <= '0;
      end
      if (o_expire) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 8085-style bus cycle controller.
// Sequences one machine cycle (OF/MR/MW/IOR/IOW/HALT) per accepted request through
// T1, T2, optional TWAIT, T3 and, for opcode fetch, T4 (and T5/T6 when mc_long).
// Also handles HALT (THALT until intr) and bus hold (THOLD with hlda).
// Ports:
//   phi1, reset_n                  clock, asynchronous active-low reset
//   mc_req/mc_type/mc_long         request from the sequencer
//   mc_addr/mc_wdata               cycle address and write data
//   ready, hold, intr, ad_in       external READY, HOLD, wake-from-halt, AD input
//   mc_ack, mc_done                accept pulse, completion pulse
//   rdata                          data captured at the end of T3 of read cycles
//   ad_out/ad_oe, a_hi/bus_oe      multiplexed AD bus, upper address and bus enable
//   ALE, RDn, WRn, IOMn, S1, S0    bus control pins
//   hlda                           hold acknowledge
//   t_state                        one-hot {T1,T2,T3,T4,T5,T6,Treset}
//   wait_err                       sticky wait-limit overflow
module bus_cycle_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        phi1,
  input  logic        reset_n,
  input  logic        mc_req,
  input  logic [2:0]  mc_type,
  input  logic        mc_long,
  input  logic [15:0] mc_addr,
  input  logic [7:0]  mc_wdata,
  input  logic        ready,
  input  logic        hold,
  input  logic        intr,
  input  logic [7:0]  ad_in,
  output logic        mc_ack,
  output logic        mc_done,
  output logic [7:0]  rdata,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic [7:0]  a_hi,
  output logic        bus_oe,
  output logic        ALE,
  output logic        RDn,
  output logic        WRn,
  output logic        IOMn,
  output logic        S1,
  output logic        S0,
  output logic        hlda,
  output logic [6:0]  t_state,
  output logic        wait_err
);

  bus_state_e  r_state;
  bus_state_e  w_state_d;
  logic [2:0]  r_type;
  logic        r_long;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;

  logic        w_final;
  logic        w_accept;
  logic        w_expire;
  logic        w_in_cycle;
  logic        w_is_read;
  logic        w_is_write;
  bus_state_e  w_end_next;

  assign w_is_read  = mc_is_read(r_type);
  assign w_is_write = mc_is_write(r_type);

  // Last T-state of the current machine cycle; doubles as an accept point.
  assign w_final = ((r_state == StT3) && (r_type != McOf)) ||
                   ((r_state == StT4) && !r_long) ||
                   (r_state == StT6);

  // Hold has priority over a new request; reserved types are never acknowledged.
  assign w_accept = ((r_state == StTreset) || w_final) && mc_req && !hold &&
                    mc_type_valid(mc_type);

  // Gated so that a request held during reset cannot pulse mc_ack.
  assign mc_ack  = w_accept && reset_n;
  assign mc_done = w_final || ((r_state == StThalt) && intr);

  assign w_end_next = hold ? StThold : (w_accept ? StT1 : StTreset);

  wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .i_clk      (phi1),
    .i_rst_n    (reset_n),
    .i_in_wait  (r_state == StTwait),
    .i_ready    (ready),
    .o_expire   (w_expire),
    .o_wait_err (wait_err)
  );

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StTreset;
      r_type  <= 3'b000;
      r_long  <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_type  <= mc_type;
        r_long  <= mc_long;
        r_addr  <= mc_addr;
        r_wdata <= mc_wdata;
      end
      if ((r_state == StT3) && w_is_read) begin
        r_rdata <= ad_in;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StTreset: w_state_d = w_end_next;
      StT1:     w_state_d = (r_type == McHalt) ? StThalt : StT2;
      StT2:     w_state_d = ready ? StT3 : StTwait;
      StTwait:  w_state_d = (ready || w_expire) ? StT3 : StTwait;
      StT3:     w_state_d = (r_type == McOf) ? StT4 : w_end_next;
      StT4:     w_state_d = r_long ? StT5 : w_end_next;
      StT5:     w_state_d = StT6;
      StT6:     w_state_d = w_end_next;
      StThalt:  w_state_d = intr ? StTreset : StThalt;
      StThold:  w_state_d = hold ? StThold : StTreset;
      default:  w_state_d = StTreset;
    endcase
  end

  // Status (IO/M, S1/S0, upper address) is held for the whole cycle including THALT.
  assign w_in_cycle = (r_state != StTreset) && (r_state != StThold);
  assign a_hi       = w_in_cycle ? r_addr[15:8] : 8'h00;
  assign rdata      = r_rdata;

  always_comb begin
    ALE      = 1'b0;
    RDn      = 1'b1;
    WRn      = 1'b1;
    IOMn     = 1'b0;
    {S1, S0} = 2'b00;
    ad_out   = 8'h00;
    ad_oe    = 1'b0;
    bus_oe   = 1'b1;
    hlda     = 1'b0;
    t_state  = TsNone;
    if (w_in_cycle) begin
      IOMn     = mc_is_io(r_type);
      {S1, S0} = mc_status(r_type);
    end
    case (r_state)
      StTreset: t_state = TsTreset;
      StT1: begin
        t_state = TsT1;
        ALE     = 1'b1;
        ad_out  = r_addr[7:0];
        ad_oe   = 1'b1;
      end
      StT2, StTwait, StT3: begin
        if (r_state == StT2) t_state = TsT2;
        if (r_state == StT3) t_state = TsT3;
        if (w_is_read) begin
          RDn = 1'b0;
        end
        if (w_is_write) begin
          WRn    = 1'b0;
          ad_out = r_wdata;
          ad_oe  = 1'b1;
        end
      end
      StT4:    t_state = TsT4;
      StT5:    t_state = TsT5;
      StT6:    t_state = TsT6;
      StThold: begin
        hlda   = 1'b1;
        bus_oe = 1'b0;
      end
      default: t_state = TsNone;
    endcase
  end

endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 0: wait-state limit per machine cycle; 0 means unlimited.
REQ-002 phi1  in  1  sole clock; all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 mc_req  in  1  sequencer requests a machine cycle.
REQ-005 mc_type  in  3  OF=000, MR=001, MW=010, IOR=011, IOW=100, HALT=101; 110/111 reserved.
REQ-006 mc_long  in  1  OF only: append T5,T6.
REQ-007 mc_addr  in  16  cycle address.
REQ-008 mc_wdata  in  8  write data.
REQ-009 ready, hold, intr  in  1 each  external READY, HOLD, wake-from-halt.
REQ-010 ad_in  in  8  AD bus input.
REQ-011 mc_ack  out  1  request accepted (one-cycle pulse).
REQ-012 mc_done  out  1  cycle complete (one-cycle pulse).
REQ-013 rdata  out  8  captured read data.
REQ-014 ad_out, ad_oe  out  8, 1  AD bus drive and enable.
REQ-015 a_hi, bus_oe  out  8, 1  A15..A8 and enable for a_hi/ALE/RDn/WRn/IOMn/S1/S0.
REQ-016 ALE, RDn, WRn, IOMn, S1, S0, hlda  out  1 each  8085 bus pins.
REQ-017 t_state  out  7  one-hot {T1,T2,T3,T4,T5,T6,Treset}; all-zero in TWAIT/THALT/THOLD.
REQ-018 wait_err  out  1  sticky MAX_WAIT overflow.

Function
REQ-019 States: TRESET(idle), T1, T2, TWAIT, T3, T4, T5, T6, THALT, THOLD.
REQ-020 Accept when mc_req & ~hold in TRESET or in a cycle's final state: mc_ack=1, latch type/long/addr/wdata, next state T1; requester holds inputs stable until mc_ack.
REQ-021 T1: ALE=1, a_hi=addr[15:8], ad_out=addr[7:0], ad_oe=1; IOMn=1 for IOR/IOW; S1S0: OF=11, MR/IOR=10, MW/IOW=01, HALT=00; status held until cycle end.
REQ-022 T2: ALE=0; reads (OF/MR/IOR) RDn=0, ad_oe=0; writes RDn=1, WRn=0, ad_out=wdata, ad_oe=1.
REQ-023 ready sampled in T2 and TWAIT: 1 -> T3, 0 -> TWAIT; strobes held through TWAIT.
REQ-024 MAX_WAIT>0: after MAX_WAIT consecutive TWAIT cycles force T3 and set wait_err.
REQ-025 T3: reads capture rdata=ad_in at end of T3; RDn/WRn return to 1 on leaving T3.
REQ-026 Final state: T3 for MR/MW/IOR/IOW; T4 for OF short; T6 for OF long; mc_done=1 in final state.
REQ-027 HALT: T1 then THALT, bus_oe=1, RDn=WRn=1, ad_oe=0; intr=1 -> mc_done, TRESET.
REQ-028 hold=1 in TRESET or final state -> THOLD next, priority over mc_req; THOLD: hlda=1, ad_oe=0, bus_oe=0; hold=0 -> TRESET, hlda=0 next cycle.
REQ-029 hold mid-cycle is deferred until final state; no strobe truncated.
REQ-030 Reserved mc_type: not accepted, no mc_ack.
REQ-031 Back-to-back accept from final state has no idle cycle between T-states.

Reset
REQ-032 reset_n=0 immediately forces TRESET: ALE=0, RDn=WRn=1, IOMn=0, S1S0=00, ad_oe=0, bus_oe=1, hlda=0, mc_ack=mc_done=0, rdata=0, wait_err=0, t_state=0000001, including mid-cycle.

Structure
REQ-033 Package bus_pkg holds mc_type encodings, state enum, and one-hot T-state constants shared with the decode sequencer.
REQ-034 One sub-module, wait_counter, implements MAX_WAIT counting and wait_err.

Verification
REQ-035 MR addr 0x1234, ready=1, ad_in=0x5A -> T1/T2/T3, ALE only in T1, RDn=0 T2-T3, rdata=0x5A, mc_done in T3.
REQ-036 MW addr 0x2000 data 0xC3, ready=0 for 2 cycles -> two TWAIT, WRn=0 T2..T3, ad_out=0xC3, S1S0=01.
REQ-037 OF mc_long=1 then MR back-to-back -> T1..T6 then T1 immediately, S1S0=11 then 10.
REQ-038 hold=1 during T2 of MR -> cycle completes, THOLD, hlda=1, outputs disabled; hold=0 -> hlda=0, accept next request.
REQ-039 MAX_WAIT=3, ready=0 -> 3 TWAIT, forced T3, wait_err=1; reset_n=0 mid-T2 -> all outputs at REQ-032 values asynchronously.
